mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of each core pipeline. Sits between the EX/MEM register and mem_wb_buffer.
//  Performs loads and stores over a req/gnt/rvalid data-memory port and formats LB/LH/LW/LBU/LHU data.
//  Stalls upstream pipeline registers until the access completes.
//  Drives mem_wb_buffer inputs directly; that buffer registers them.
// PARAMETERS
//  BUS_TIMEOUT  256  cycles waiting for gnt or rvalid before bus_err; 0 = timeout disabled
// PORTS
//  clk              in   1   clock
//  rst              in   1   asynchronous, active-high reset
//  ex_valid         in   1   EX/MEM holds a valid instruction
//  ex_alu_result    in   32  effective address / ALU result
//  ex_rs2_data      in   32  store data
//  ex_rd_addr       in   5   destination register
//  ex_pc_plus_4     in   32  link value
//  ex_funct3        in   3   access size/sign (RV32I encoding)
//  ex_mem_read      in   1   load
//  ex_mem_write     in   1   store
//  ex_reg_write     in   1   writes rd
//  ex_mem_to_reg    in   1   WB selects load data
//  dmem_req         out  1   request valid
//  dmem_we          out  1   1 = store
//  dmem_addr        out  32  word address ({addr[31:2],2'b00})
//  dmem_wdata       out  32  store data, lane-replicated
//  dmem_be          out  4   byte enables
//  dmem_gnt         in   1   request accepted this cycle
//  dmem_rvalid      in   1   load data valid
//  dmem_rdata       in   32  load data (full word)
//  mem_alu_result_out, mem_read_data_out (32), mem_rd_addr_out (5), mem_pc_plus_4_out (32),
//  mem_reg_write_out, mem_mem_to_reg_out (1)   out   to mem_wb_buffer
//  mem_stall        out  1   hold PC, IF/ID, ID/EX, EX/MEM
//  misalign_exc     out  1   1-cycle pulse: misaligned access dropped
//  bus_err          out  1   1-cycle pulse: timeout, access abandoned
// BEHAVIOUR
//  - Reset: state=IDLE, timeout counter=0, load data reg=0.
//    All registered outputs 0. dmem_req=0, mem_stall=0.
//  - memop = ex_valid & (ex_mem_read | ex_mem_write).
//    Misaligned when: W with addr[1:0]!=0, H/HU with addr[0]!=0.
//  - Non-memop: zero latency. ex_* pass through. mem_reg_write_out = ex_valid & ex_reg_write. No stall.
//  - States:
//    - IDLE: on aligned memop, assert dmem_req and mem_stall.
//      On gnt, go to WAIT_R if load, DONE if store; otherwise stay in IDLE with req held.
//    - WAIT_R: mem_stall=1, dmem_req=0. On rvalid, capture formatted load data and go to DONE.
//    - DONE: mem_stall=0 for exactly 1 cycle. Outputs valid; mem_read_data_out = captured data.
//      Return to IDLE. The stall drop lets EX/MEM advance, so the instruction is never reissued.
//  - While mem_stall=1: mem_reg_write_out=0 (bubble into mem_wb_buffer).
//  - Request held stable (addr/we/wdata/be) from assert until gnt. Inputs are stable because upstream is stalled.
//  - Store: B → be=1<<addr[1:0], wdata={4{rs2[7:0]}}. H → be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}. W → be=1111.
//  - Load: select lane by addr[1:0]. B/H sign-extend, BU/HU zero-extend. W passes through.
//  - Misaligned memop:
//    - No request and no stall.
//    - misalign_exc=1 for that cycle; mem_reg_write_out=0.
//  - rvalid is accepted only in WAIT_R; rvalid in IDLE/DONE is ignored. gnt is sampled only while req=1.
//  - Timeout: counter increments each cycle in IDLE-with-req or WAIT_R.
//    At BUS_TIMEOUT: bus_err pulse, go to DONE with reg_write_out=0. Counter clears on gnt/rvalid/exit.
//  - Unsupported funct3 (e.g. 3'b011): treated as misaligned.
//  - Reset mid-access: immediate return to IDLE, req dropped. A late rvalid is ignored.
// STRUCTURE
//  - Shared package riscv_mem_pkg: funct3 constants (F3_LB..F3_LHU, F3_SB..F3_SW), state encoding (IDLE/WAIT_R/DONE).
//  - One sub-module, lsu_load_formatter: combinational lane select and sign/zero extension (rdata, addr[1:0], funct3 → 32b).
// TESTING
//  - ALU op, rd=5, result 0x1234 → same cycle reg_write_out=1, alu_result_out=0x1234, stall=0.
//  - LB addr 0x103, rdata 0x80FF_0000, gnt at cycle 0, rvalid at cycle 2 → stall for 3 cycles.
//    DONE cycle: read_data_out=0xFFFF_FF80, reg_write_out=1.
//  - SH addr 0x202, rs2=0xABCD_1234, gnt delayed 3 cycles → req held for 4 cycles, be=1100,
//    wdata=0x1234_1234, dmem_addr=0x200; DONE then IDLE.
//  - LW addr 0x101 → no req, misalign_exc=1 for 1 cycle, reg_write_out=0, stall=0.
//  - LHU with rvalid never returned, BUS_TIMEOUT=4 → bus_err pulse after 4 WAIT_R cycles, reg_write_out=0, back to IDLE.
//  - rst asserted in WAIT_R, then rvalid arrives after release → req=0, state IDLE, rvalid ignored, outputs 0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory path: RV32I funct3 encodings, MEM-stage state
// encoding and the store lane helpers.
package riscv_mem_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_R = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    // Unsupported size/sign encodings are folded into the misaligned case.
    function automatic logic access_bad(input logic [2:0] f3, input logic [1:0] a,
                                        input logic is_store);
        logic bad;
        case (f3)
            F3_LB:   bad = 1'b0;
            F3_LH:   bad = a[0];
            F3_LW:   bad = |a;
            F3_LBU:  bad = is_store;
            F3_LHU:  bad = is_store | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3)
            F3_SB:   be = 4'b0001 << a;
            F3_SH:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3,
                                                    input logic [XLEN-1:0] rs2);
        logic [XLEN-1:0] wd;
        case (f3)
            F3_SB:   wd = {4{rs2[7:0]}};
            F3_SH:   wd = {2{rs2[15:0]}};
            default: wd = rs2;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/lsu_load_formatter.sv
// Load data formatting: picks the addressed byte/half lane and sign- or zero-extends it.
module lsu_load_formatter
    import riscv_mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over the req/gnt/rvalid data port, stalls upstream
// while an access is outstanding and feeds mem_wb_buffer combinationally.
module mem_access_stage
    import riscv_mem_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [4:0]      ex_rd_addr,
    input  logic [XLEN-1:0] ex_pc_plus_4,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_reg_write,
    input  logic            ex_mem_to_reg,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] mem_alu_result_out,
    output logic [XLEN-1:0] mem_read_data_out,
    output logic [4:0]      mem_rd_addr_out,
    output logic [XLEN-1:0] mem_pc_plus_4_out,
    output logic            mem_reg_write_out,
    output logic            mem_mem_to_reg_out,
    output logic            mem_stall,
    output logic            misalign_exc,
    output logic            bus_err
);

    localparam int unsigned CNT_W   = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1;

    mem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            to_q, to_d;

    logic            memop;
    logic            is_store;
    logic            misaligned;
    logic            timeout_hit;
    logic            reg_write_en;
    logic [XLEN-1:0] load_fmt;

    lsu_load_formatter u_fmt (
        .rdata_i   (dmem_rdata),
        .addr_lo_i (ex_alu_result[1:0]),
        .funct3_i  (ex_funct3),
        .data_o    (load_fmt)
    );

    assign memop       = ex_valid & (ex_mem_read | ex_mem_write);
    assign is_store    = ex_mem_write & ~ex_mem_read;
    assign misaligned  = access_bad(ex_funct3, ex_alu_result[1:0], is_store);
    assign timeout_hit = (BUS_TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
        end
    end

    // Next state and stage control; gnt/rvalid take priority over a same-cycle timeout.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        to_d         = to_q;
        dmem_req     = 1'b0;
        mem_stall    = 1'b0;
        misalign_exc = 1'b0;
        reg_write_en = ex_valid & ex_reg_write;

        case (state_q)
            IDLE: begin
                to_d = 1'b0;
                if (memop) begin
                    reg_write_en = 1'b0;
                    if (misaligned) begin
                        misalign_exc = 1'b1;
                    end else begin
                        dmem_req  = 1'b1;
                        mem_stall = 1'b1;
                        if (dmem_gnt) begin
                            cnt_d   = '0;
                            state_d = is_store ? DONE : WAIT_R;
                        end else if (timeout_hit) begin
                            cnt_d   = '0;
                            to_d    = 1'b1;
                            state_d = DONE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            WAIT_R: begin
                mem_stall    = 1'b1;
                reg_write_en = 1'b0;
                if (dmem_rvalid) begin
                    rdata_d = load_fmt;
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    cnt_d   = '0;
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (to_q) begin
                    reg_write_en = 1'b0;
                end
                cnt_d   = '0;
                to_d    = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                to_d    = 1'b0;
            end
        endcase
    end

    // Request payload is driven only while req is up, otherwise the bus idles at zero.
    assign dmem_we    = dmem_req & is_store;
    assign dmem_addr  = dmem_req ? {ex_alu_result[31:2], 2'b00} : '0;
    assign dmem_wdata = dmem_req ? store_wdata(ex_funct3, ex_rs2_data) : '0;
    assign dmem_be    = dmem_req ? (is_store ? store_be(ex_funct3, ex_alu_result[1:0]) : 4'b1111)
                                 : 4'b0000;

    assign mem_alu_result_out = ex_alu_result;
    assign mem_read_data_out  = rdata_q;
    assign mem_rd_addr_out    = ex_rd_addr;
    assign mem_pc_plus_4_out  = ex_pc_plus_4;
    assign mem_mem_to_reg_out = ex_mem_to_reg;
    assign mem_reg_write_out  = reg_write_en;
    assign bus_err            = (state_q == DONE) & to_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expectations (BUS_TIMEOUT = 4).
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_pc_plus_4;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] mem_alu_result_out;
    logic [31:0] mem_read_data_out;
    logic [4:0]  mem_rd_addr_out;
    logic [31:0] mem_pc_plus_4_out;
    logic        mem_reg_write_out;
    logic        mem_mem_to_reg_out;
    logic        mem_stall;
    logic        misalign_exc;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.BUS_TIMEOUT(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .ex_valid           (ex_valid),
        .ex_alu_result      (ex_alu_result),
        .ex_rs2_data        (ex_rs2_data),
        .ex_rd_addr         (ex_rd_addr),
        .ex_pc_plus_4       (ex_pc_plus_4),
        .ex_funct3          (ex_funct3),
        .ex_mem_read        (ex_mem_read),
        .ex_mem_write       (ex_mem_write),
        .ex_reg_write       (ex_reg_write),
        .ex_mem_to_reg      (ex_mem_to_reg),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_be            (dmem_be),
        .dmem_gnt           (dmem_gnt),
        .dmem_rvalid        (dmem_rvalid),
        .dmem_rdata         (dmem_rdata),
        .mem_alu_result_out (mem_alu_result_out),
        .mem_read_data_out  (mem_read_data_out),
        .mem_rd_addr_out    (mem_rd_addr_out),
        .mem_pc_plus_4_out  (mem_pc_plus_4_out),
        .mem_reg_write_out  (mem_reg_write_out),
        .mem_mem_to_reg_out (mem_mem_to_reg_out),
        .mem_stall          (mem_stall),
        .misalign_exc       (misalign_exc),
        .bus_err            (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_alu_result = 0; ex_rs2_data = 0; ex_rd_addr = 0; ex_pc_plus_4 = 0;
        ex_funct3 = 0; ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; ex_mem_to_reg = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic set_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_reg_write = 1; ex_mem_to_reg = 1;
        ex_funct3 = f3; ex_alu_result = addr; ex_rd_addr = rd;
    endtask

    // Load with immediate gnt and rvalid one cycle later; checks the DONE-cycle result.
    task automatic load_vec(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        next_cycle();
        set_load(f3, addr, 5'd9);
        dmem_gnt = 1;
        next_cycle();
        dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = rdata;
        next_cycle();
        dmem_rvalid = 0;
        @(negedge clk);
        chk({tag, "_data"}, mem_read_data_out, exp);
        chk({tag, "_stall"}, 32'(mem_stall), 32'd0);
        next_cycle();
        clear_ex();
    endtask

    initial begin
        clear_ex();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_rdata", mem_read_data_out, 32'd0);
        chk("rst_busy_flags", {29'd0, mem_reg_write_out, misalign_exc, bus_err}, 32'd0);
        rst = 0;

        // ALU pass-through
        next_cycle();
        ex_valid = 1; ex_reg_write = 1; ex_rd_addr = 5'd5; ex_alu_result = 32'h1234;
        ex_pc_plus_4 = 32'h44;
        @(negedge clk);
        chk("alu_rw", 32'(mem_reg_write_out), 32'd1);
        chk("alu_res", mem_alu_result_out, 32'h1234);
        chk("alu_rd", 32'(mem_rd_addr_out), 32'd5);
        chk("alu_pc4", mem_pc_plus_4_out, 32'h44);
        chk("alu_stall", 32'(mem_stall), 32'd0);
        chk("alu_req", 32'(dmem_req), 32'd0);

        // LB 0x103: gnt cycle 0, rvalid cycle 2
        next_cycle();
        clear_ex();
        set_load(3'b000, 32'h103, 5'd7);
        dmem_gnt = 1; dmem_rdata = 32'h80FF_0000;
        @(negedge clk);
        chk("lb_c0_req", 32'(dmem_req), 32'd1);
        chk("lb_c0_stall", 32'(mem_stall), 32'd1);
        chk("lb_c0_addr", dmem_addr, 32'h100);
        chk("lb_c0_we", 32'(dmem_we), 32'd0);
        chk("lb_c0_rw", 32'(mem_reg_write_out), 32'd0);
        next_cycle();
        dmem_gnt = 0;
        @(negedge clk);
        chk("lb_c1_stall", 32'(mem_stall), 32'd1);
        chk("lb_c1_req", 32'(dmem_req), 32'd0);
        next_cycle();
        dmem_rvalid = 1;
        @(negedge clk);
        chk("lb_c2_stall", 32'(mem_stall), 32'd1);
        next_cycle();
        dmem_rvalid = 0;
        @(negedge clk);
        chk("lb_done_stall", 32'(mem_stall), 32'd0);
        chk("lb_done_data", mem_read_data_out, 32'hFFFF_FF80);
        chk("lb_done_rw", 32'(mem_reg_write_out), 32'd1);
        chk("lb_done_rd", 32'(mem_rd_addr_out), 32'd7);
        next_cycle();
        clear_ex();
        dmem_rvalid = 1; dmem_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("idle_stall", 32'(mem_stall), 32'd0);
        next_cycle();
        dmem_rvalid = 0;
        @(negedge clk);
        chk("idle_rvalid_ignored", mem_read_data_out, 32'hFFFF_FF80);

        // SH 0x202 with gnt delayed by 3 cycles
        next_cycle();
        ex_valid = 1; ex_mem_write = 1; ex_funct3 = 3'b001; ex_alu_result = 32'h202;
        ex_rs2_data = 32'hABCD_1234;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_gnt = 1;
            @(negedge clk);
            chk($sformatf("sh_c%0d_req", i), 32'(dmem_req), 32'd1);
            chk($sformatf("sh_c%0d_be", i), 32'(dmem_be), 32'hC);
            chk($sformatf("sh_c%0d_wd", i), dmem_wdata, 32'h1234_1234);
            chk($sformatf("sh_c%0d_addr", i), dmem_addr, 32'h200);
            chk($sformatf("sh_c%0d_we", i), 32'(dmem_we), 32'd1);
            next_cycle();
        end
        dmem_gnt = 0;
        @(negedge clk);
        chk("sh_done_req", 32'(dmem_req), 32'd0);
        chk("sh_done_stall", 32'(mem_stall), 32'd0);
        chk("sh_done_err", 32'(bus_err), 32'd0);
        next_cycle();
        clear_ex();
        @(negedge clk);
        chk("sh_idle_stall", 32'(mem_stall), 32'd0);

        // SB 0x301
        next_cycle();
        ex_valid = 1; ex_mem_write = 1; ex_funct3 = 3'b000; ex_alu_result = 32'h301;
        ex_rs2_data = 32'h0000_0055; dmem_gnt = 1;
        @(negedge clk);
        chk("sb_be", 32'(dmem_be), 32'h2);
        chk("sb_wd", dmem_wdata, 32'h5555_5555);
        next_cycle();
        dmem_gnt = 0;
        @(negedge clk);
        chk("sb_done_stall", 32'(mem_stall), 32'd0);
        next_cycle();
        clear_ex();

        // LW 0x101 misaligned, then unsupported funct3
        next_cycle();
        set_load(3'b010, 32'h101, 5'd3);
        @(negedge clk);
        chk("lw_mis_req", 32'(dmem_req), 32'd0);
        chk("lw_mis_exc", 32'(misalign_exc), 32'd1);
        chk("lw_mis_rw", 32'(mem_reg_write_out), 32'd0);
        chk("lw_mis_stall", 32'(mem_stall), 32'd0);
        next_cycle();
        clear_ex();
        @(negedge clk);
        chk("lw_mis_pulse", 32'(misalign_exc), 32'd0);
        next_cycle();
        set_load(3'b011, 32'h100, 5'd3);
        @(negedge clk);
        chk("f3_bad_exc", 32'(misalign_exc), 32'd1);
        chk("f3_bad_req", 32'(dmem_req), 32'd0);
        next_cycle();
        clear_ex();

        // Load formatting vectors
        load_vec("lh", 3'b001, 32'h102, 32'h8001_0000, 32'hFFFF_8001);
        load_vec("lbu", 3'b100, 32'h101, 32'h0000_FF00, 32'h0000_00FF);
        load_vec("lw", 3'b010, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load_vec("lhu", 3'b101, 32'h100, 32'h1234_8765, 32'h0000_8765);

        // LHU timeout: rvalid never comes
        next_cycle();
        set_load(3'b101, 32'h200, 5'd4);
        dmem_gnt = 1;
        next_cycle();
        dmem_gnt = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("to_w%0d_stall", i), 32'(mem_stall), 32'd1);
            chk($sformatf("to_w%0d_err", i), 32'(bus_err), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("to_err", 32'(bus_err), 32'd1);
        chk("to_stall", 32'(mem_stall), 32'd0);
        chk("to_rw", 32'(mem_reg_write_out), 32'd0);
        next_cycle();
        clear_ex();
        @(negedge clk);
        chk("to_err_pulse", 32'(bus_err), 32'd0);
        chk("to_idle_stall", 32'(mem_stall), 32'd0);

        // Reset while in WAIT_R, late rvalid afterwards
        next_cycle();
        set_load(3'b000, 32'h100, 5'd6);
        dmem_gnt = 1;
        next_cycle();
        dmem_gnt = 0;
        @(negedge clk);
        chk("rw_wait_stall", 32'(mem_stall), 32'd1);
        next_cycle();
        clear_ex();
        rst = 1;
        @(negedge clk);
        chk("rw_rst_req", 32'(dmem_req), 32'd0);
        chk("rw_rst_stall", 32'(mem_stall), 32'd0);
        next_cycle();
        rst = 0;
        dmem_rvalid = 1; dmem_rdata = 32'h0000_0080;
        next_cycle();
        dmem_rvalid = 0;
        @(negedge clk);
        chk("rw_late_rdata", mem_read_data_out, 32'd0);
        chk("rw_late_stall", 32'(mem_stall), 32'd0);
        chk("rw_late_flags", {29'd0, mem_reg_write_out, dmem_req, bus_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
